// File: rtl/dotp_seq.sv
// dotp_seq: streams packed int8 operand beats through a 4-lane MAC and accumulates one result per job.
// Define DOTP_SAT_EN for saturating accumulation and the sticky sat_flag output.
module dotp_seq #(
  parameter int WIDTH_SUM = 32,
  parameter int ACC_W = 40,
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  output logic [31:0]          mac_a,
  output logic [31:0]          mac_b,
  output logic [2:0]           mac_valid,
  input  logic [WIDTH_SUM-1:0] mac_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef DOTP_SAT_EN
  output logic                 sat_flag,
`endif
  output logic [ACC_W-1:0]     out_data
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0] r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-2:0] r_beats;
  logic [2:0] r_last;
  logic [LEN_W:0] w_len3;
  logic [ACC_W-1:0] w_ext, w_next;
  logic w_start, w_acc_en, w_last_beat;
  // One extra bit keeps ceil(L/4) exact for L = 2^LEN_W-1.
  assign w_len3 = {1'b0, cfg_len} + (LEN_W+1)'(3);
  assign w_start = r_state == S_IDLE && start;
  assign in_ready = r_state == S_RUN;
  assign busy = r_state != S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign out_data = r_acc;
  assign mac_a = in_a;
  assign mac_b = in_b;
  assign w_last_beat = r_beats == (LEN_W-1)'(1);
  assign mac_valid = (in_ready && w_last_beat) ? r_last : 3'd4;
  assign w_acc_en = in_ready && in_valid;
  assign w_ext = ACC_W'($signed(mac_sum));
`ifdef DOTP_SAT_EN
  logic [ACC_W:0] w_wide;
  logic w_ovf, r_sat;
  assign w_wide = {r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext};
  assign w_ovf = w_wide[ACC_W] ^ w_wide[ACC_W-1];
  assign w_next = !w_ovf ? w_wide[ACC_W-1:0] :
                  w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign sat_flag = r_sat;
  always_ff @(posedge clk) begin
    if (!rst_n) r_sat <= 1'b0;
    else if (w_start) r_sat <= 1'b0;
    else if (w_acc_en && w_ovf) r_sat <= 1'b1;
  end
`else
  assign w_next = r_acc + w_ext;
`endif
  // The accumulator doubles as the registered result once the last beat lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc <= '0;
      r_beats <= '0;
      r_last <= 3'd4;
    end else if (w_start) begin
      r_acc <= '0;
      r_beats <= w_len3[LEN_W:2];
      r_last <= cfg_len[1:0] == 2'd0 ? 3'd4 : {1'b0, cfg_len[1:0]};
      r_state <= cfg_len == '0 ? S_DONE : S_RUN;
    end else if (w_acc_en) begin
      r_acc <= w_next;
      r_beats <= r_beats - (LEN_W-1)'(1);
      r_state <= w_last_beat ? S_DONE : S_RUN;
    end else if (out_valid && out_ready) begin
      r_state <= S_IDLE;
    end
  end
endmodule
